// File: rtl/imem_dmem_arbiter.sv
// Unified-memory arbiter between instruction fetch and data access.
// Data has priority; fetch is forced through after MAX_WAIT data grants.
module imem_dmem_arbiter #(
    parameter int LATENCY  = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        flush,
    output logic        if_grant,
    output logic        if_done,
    output logic [15:0] if_data,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_grant,
    output logic        dm_done,
    output logic [15:0] dm_rdata,
    output logic        dm_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic          own_if;
    logic          wr_q;
    logic          cancel;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rdata_q;
    logic          err_q;
    logic [3:0]    cnt;
    logic [WW-1:0] wait_cnt;
    logic [15:0]   if_data_q;
    logic          if_err_q;
    logic [15:0]   dm_data_q;
    logic          dm_err_q;

    logic idle;
    logic pick_if;
    logic pick_dm;
    logic win;

    // Grants are decided combinationally so the grant shares the mem_en cycle.
    assign idle    = (state == IDLE) && rst;
    assign pick_if = idle && if_req && !flush && (!dm_req || wait_cnt == WMAX);
    assign pick_dm = idle && dm_req && !pick_if;
    assign win     = pick_if || pick_dm;

    assign if_grant  = pick_if;
    assign dm_grant  = pick_dm;
    assign mem_en    = win;
    assign mem_addr  = win ? (pick_if ? if_addr : dm_addr) : addr_q;
    assign mem_wr    = win ? (pick_dm && dm_wr) : wr_q;
    assign mem_wdata = win ? (pick_dm ? dm_wdata : 16'h0) : wdata_q;
    assign busy      = (state != IDLE);

    // A flush arriving in the done cycle still suppresses the fetch result.
    assign if_done  = (state == DONE) && own_if && !cancel && !flush;
    assign dm_done  = (state == DONE) && !own_if;
    assign if_data  = if_done ? rdata_q : if_data_q;
    assign if_err   = if_done ? err_q : if_err_q;
    assign dm_rdata = dm_done ? rdata_q : dm_data_q;
    assign dm_err   = dm_done ? err_q : dm_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            own_if    <= 1'b0;
            wr_q      <= 1'b0;
            cancel    <= 1'b0;
            addr_q    <= 16'h0;
            wdata_q   <= 16'h0;
            rdata_q   <= 16'h0;
            err_q     <= 1'b0;
            cnt       <= 4'h0;
            wait_cnt  <= '0;
            if_data_q <= 16'h0;
            if_err_q  <= 1'b0;
            dm_data_q <= 16'h0;
            dm_err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_if)
                        wait_cnt <= '0;
                    else if (pick_dm && if_req) begin
                        if (wait_cnt != WMAX)
                            wait_cnt <= wait_cnt + WW'(1);
                    end else if (!if_req)
                        wait_cnt <= '0;
                    if (win) begin
                        own_if  <= pick_if;
                        addr_q  <= mem_addr;
                        wr_q    <= mem_wr;
                        wdata_q <= mem_wdata;
                        cancel  <= 1'b0;
                        if (LATENCY == 1) begin
                            rdata_q <= mem_wr ? 16'h0 : mem_rdata;
                            err_q   <= mem_err;
                            state   <= DONE;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (own_if && flush)
                        cancel <= 1'b1;
                    cnt <= cnt - 4'h1;
                    if (cnt == 4'h1) begin
                        rdata_q <= mem_wr ? 16'h0 : mem_rdata;
                        err_q   <= mem_err;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (if_done) begin
                        if_data_q <= rdata_q;
                        if_err_q  <= err_q;
                    end
                    if (dm_done) begin
                        dm_data_q <= rdata_q;
                        dm_err_q  <= err_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: vector table plus
// hand-written multi-cycle sequences (fairness, flush, write, reset).
module tb_imem_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        flush;
    logic        if_grant;
    logic        if_done;
    logic [15:0] if_data;
    logic        if_err;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_grant;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        dm_err;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    imem_dmem_arbiter #(.LATENCY(4), .MAX_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_grant(if_grant), .if_done(if_done),
        .if_data(if_data), .if_err(if_err),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_grant(dm_grant), .dm_done(dm_done),
        .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed contents plus one writable location.
    function automatic logic [15:0] base(input logic [15:0] a);
        case (a)
            16'h0040: return 16'hA5C3;
            16'h0050: return 16'hBEEF;
            16'h0060: return 16'h7777;
            16'h0100: return 16'h1111;
            16'h0300: return 16'h3333;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    logic        w_valid = 1'b0;
    logic [15:0] w_addr  = 16'h0;
    logic [15:0] w_data  = 16'h0;
    logic        err_on  = 1'b0;

    always @(posedge clk)
        if (mem_en && mem_wr) begin
            w_valid <= 1'b1;
            w_addr  <= mem_addr;
            w_data  <= mem_wdata;
        end

    assign mem_rdata = (w_valid && w_addr == mem_addr) ? w_data : base(mem_addr);
    assign mem_err   = err_on && (mem_addr == 16'h0060);

    typedef struct {
        logic        ifr;
        logic [15:0] ia;
        logic        fl;
        logic        dr;
        logic [15:0] da;
        logic [5:0]  ctl;
        logic [15:0] idata;
        logic [15:0] drd;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_if, input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            @(negedge clk);
            got = is_if ? if_done : dm_done;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: done not seen within 20 cycles", nm);
        end
    endtask

    logic [5:0] ctl;
    int         gseq[$];
    bit         seen;
    int         cyc;

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 16'h0040; flush = 1'b0;
        dm_req = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
        // ctl = {if_grant, dm_grant, mem_en, if_done, dm_done, busy}
        tv[0]  = '{1, 16'h0040, 0, 0, 16'h0,    6'b101000, 16'h0000, 16'h0000};
        tv[1]  = '{1, 16'h0040, 0, 0, 16'h0,    6'b000001, 16'h0000, 16'h0000};
        tv[2]  = '{1, 16'h0040, 0, 0, 16'h0,    6'b000001, 16'h0000, 16'h0000};
        tv[3]  = '{1, 16'h0040, 0, 0, 16'h0,    6'b000001, 16'h0000, 16'h0000};
        tv[4]  = '{1, 16'h0040, 0, 0, 16'h0,    6'b000101, 16'hA5C3, 16'h0000};
        tv[5]  = '{0, 16'h0040, 0, 0, 16'h0,    6'b000000, 16'hA5C3, 16'h0000};
        tv[6]  = '{1, 16'h0040, 0, 1, 16'h0100, 6'b011000, 16'hA5C3, 16'h0000};
        tv[7]  = '{1, 16'h0040, 0, 1, 16'h0100, 6'b000001, 16'hA5C3, 16'h0000};
        tv[8]  = '{1, 16'h0040, 0, 1, 16'h0100, 6'b000001, 16'hA5C3, 16'h0000};
        tv[9]  = '{1, 16'h0040, 0, 1, 16'h0100, 6'b000001, 16'hA5C3, 16'h0000};
        tv[10] = '{1, 16'h0040, 0, 1, 16'h0100, 6'b000011, 16'hA5C3, 16'h1111};
        tv[11] = '{1, 16'h0040, 0, 0, 16'h0,    6'b101000, 16'hA5C3, 16'h1111};
        tv[12] = '{1, 16'h0040, 0, 0, 16'h0,    6'b000001, 16'hA5C3, 16'h1111};
        tv[13] = '{1, 16'h0040, 0, 0, 16'h0,    6'b000001, 16'hA5C3, 16'h1111};
        tv[14] = '{1, 16'h0040, 0, 0, 16'h0,    6'b000001, 16'hA5C3, 16'h1111};
        tv[15] = '{1, 16'h0040, 0, 0, 16'h0,    6'b000101, 16'hA5C3, 16'h1111};
        tv[16] = '{1, 16'h0040, 1, 0, 16'h0,    6'b000000, 16'hA5C3, 16'h1111};
        tv[17] = '{0, 16'h0040, 0, 0, 16'h0,    6'b000000, 16'hA5C3, 16'h1111};

        // reset with a request pending: nothing may be granted
        tick(); tick();
        @(negedge clk);
        ctl = {if_grant, dm_grant, mem_en, if_done, dm_done, busy};
        chk("reset ctl", 16'(ctl), 16'h0);
        chk("reset if_data", if_data, 16'h0);
        chk("reset dm_rdata", dm_rdata, 16'h0);
        chk("reset mem_addr", mem_addr, 16'h0);
        tick();
        if_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            tick();
            if_req = tv[i].ifr; if_addr = tv[i].ia; flush = tv[i].fl;
            dm_req = tv[i].dr; dm_addr = tv[i].da; dm_wr = 1'b0;
            @(negedge clk);
            ctl = {if_grant, dm_grant, mem_en, if_done, dm_done, busy};
            chk($sformatf("row%0d ctl", i), 16'(ctl), 16'(tv[i].ctl));
            chk($sformatf("row%0d if_data", i), if_data, tv[i].idata);
            chk($sformatf("row%0d dm_rdata", i), dm_rdata, tv[i].drd);
        end

        // fairness: both requesters held high
        tick();
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_addr = 16'h0100;
        for (int k = 0; k < 60 && gseq.size() < 6; k++) begin
            @(negedge clk);
            if (if_grant && dm_grant) chk("dual grant", 16'h1, 16'h0);
            if (if_grant) gseq.push_back(1);
            if (dm_grant) gseq.push_back(0);
            if (gseq.size() < 6) tick();
        end
        while (gseq.size() < 6) gseq.push_back(9);
        chk("grant0", 16'(gseq[0]), 16'd0);
        chk("grant1", 16'(gseq[1]), 16'd0);
        chk("grant2", 16'(gseq[2]), 16'd1);
        chk("grant3", 16'(gseq[3]), 16'd0);
        chk("grant4", 16'(gseq[4]), 16'd0);
        chk("grant5", 16'(gseq[5]), 16'd1);
        tick();
        dm_req = 1'b0;
        @(negedge clk);
        wait_done(1'b1, "fair if_done");
        tick();
        if_req = 1'b0;
        @(negedge clk);

        // flush of an in-flight fetch
        seen = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 16'h0050;
        @(negedge clk);
        chk("flush if_grant", 16'(if_grant), 16'h1);
        seen |= if_done;
        tick();
        @(negedge clk);
        seen |= if_done;
        tick();
        flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        seen |= if_done;
        tick();
        flush = 1'b0; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
        @(negedge clk);
        seen |= if_done;
        chk("flush c3 dm_grant", 16'(dm_grant), 16'h0);
        tick();
        @(negedge clk);
        seen |= if_done;
        chk("flush c4 busy", 16'(busy), 16'h1);
        tick();
        @(negedge clk);
        seen |= if_done;
        chk("flush c5 busy", 16'(busy), 16'h0);
        chk("flush c5 dm_grant", 16'(dm_grant), 16'h1);
        chk("flush no if_done", 16'(seen), 16'h0);
        chk("flush if_data kept", if_data, 16'hA5C3);
        wait_done(1'b0, "flush dm_done");
        chk("flush dm_rdata", dm_rdata, 16'h3333);
        tick();
        dm_req = 1'b0;
        @(negedge clk);

        // write then read back
        tick();
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
        @(negedge clk);
        chk("wr dm_grant", 16'(dm_grant), 16'h1);
        chk("wr mem_en", 16'(mem_en), 16'h1);
        chk("wr mem_wr c0", 16'(mem_wr), 16'h1);
        chk("wr mem_wdata c0", mem_wdata, 16'h1234);
        tick();
        dm_wdata = 16'hFFFF;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("wr mem_wr c2", 16'(mem_wr), 16'h1);
        chk("wr mem_wdata c2", mem_wdata, 16'h1234);
        chk("wr mem_addr c2", mem_addr, 16'h0200);
        wait_done(1'b0, "wr dm_done");
        chk("wr dm_rdata", dm_rdata, 16'h0000);
        tick();
        dm_req = 1'b0; dm_wr = 1'b0;
        @(negedge clk);
        tick();
        dm_req = 1'b1; dm_addr = 16'h0200;
        @(negedge clk);
        chk("rd dm_grant", 16'(dm_grant), 16'h1);
        chk("rd mem_wr", 16'(mem_wr), 16'h0);
        wait_done(1'b0, "rd dm_done");
        chk("rd dm_rdata", dm_rdata, 16'h1234);
        tick();
        dm_req = 1'b0;
        @(negedge clk);

        // memory error on fetch
        err_on = 1'b1;
        tick();
        if_req = 1'b1; if_addr = 16'h0060;
        @(negedge clk);
        chk("err if_grant", 16'(if_grant), 16'h1);
        wait_done(1'b1, "err if_done");
        chk("err if_data", if_data, 16'h7777);
        chk("err if_err", 16'(if_err), 16'h1);
        tick();
        if_req = 1'b0;
        @(negedge clk);

        // reset in the middle of an erroring fetch
        tick();
        if_req = 1'b1; if_addr = 16'h0060;
        @(negedge clk);
        chk("rst if_grant", 16'(if_grant), 16'h1);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        ctl = {if_grant, dm_grant, mem_en, if_done, dm_done, busy};
        chk("rst ctl", 16'(ctl), 16'h0);
        chk("rst if_data", if_data, 16'h0);
        chk("rst if_err", 16'(if_err), 16'h0);
        chk("rst dm_rdata", dm_rdata, 16'h0);
        chk("rst mem_addr", mem_addr, 16'h0);
        chk("rst mem_wr", 16'(mem_wr), 16'h0);
        seen = 1'b0;
        for (cyc = 0; cyc < 5; cyc++) begin
            tick();
            @(negedge clk);
            seen |= if_done | if_err | busy;
        end
        chk("rst quiet", 16'(seen), 16'h0);
        tick();
        if_req = 1'b1; if_addr = 16'h0040;
        @(negedge clk);
        chk("post rst if_grant", 16'(if_grant), 16'h1);
        wait_done(1'b1, "post rst if_done");
        chk("post rst if_data", if_data, 16'hA5C3);
        chk("post rst if_err", 16'(if_err), 16'h0);
        tick();
        if_req = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
